ps2_command_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the system block to the keyboard on the shared PS2_CLK/PS2_DAT lines. This is the counterpart to the existing PS/2 receive path. It drives the open-drain pads through output enables only, sits beside the PS/2 controller in the board top level, and reports device acknowledge or failure back to the system logic.

---
 rtl/ps2_command_tx_if.sv | 27 ++
 rtl/ps2_command_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_command_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_command_tx_if.sv
// rtl/ps2_command_tx_if.sv - command handshake and status bundle between system logic and the PS/2 transmitter
interface ps2_command_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - host-to-device PS/2 command byte transmitter driving open-drain output enables
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_command_tx_if.slave  cmd,
    input  logic             ps2_clk_in,
    input  logic             ps2_dat_in,
    output logic             ps2_clk_oe,
    output logic             ps2_dat_oe
);
    localparam logic [31:0] INH_LOAD   = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] START_LOAD = 32'(START_TIMEOUT - 1);
    localparam logic [31:0] BIT_LOAD   = 32'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQUEST, S_DATA, S_ACK, S_WAIT_IDLE, S_FAIL
    } state_t;

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [9:0]  frame, frame_n;
    logic [3:0]  bitn, bitn_n;
    logic        dat_bit, dat_bit_n;
    logic [1:0]  guard, guard_n;
    logic [1:0]  clk_sync, dat_sync;
    logic        clk_prev;
    logic        clk_s, dat_s, fe;
    logic        ready_c, busy_c, done_c, error_c;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fe    = clk_prev & ~clk_s;

    // Synchronisers idle high so a released bus never looks like a falling edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            frame   <= '0;
            bitn    <= '0;
            dat_bit <= 1'b0;
            guard   <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            frame   <= frame_n;
            bitn    <= bitn_n;
            dat_bit <= dat_bit_n;
            guard   <= guard_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = (state == S_IDLE || timer == 32'd0) ? timer : timer - 32'd1;
        frame_n    = frame;
        bitn_n     = bitn;
        dat_bit_n  = dat_bit;
        guard_n    = (guard != 2'd0) ? guard - 2'd1 : guard;
        ready_c    = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        error_c    = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (cmd.cmd_valid) begin
                    frame_n = {1'b1, ~^cmd.cmd_data, cmd.cmd_data};
                    bitn_n  = 4'd0;
                    timer_n = INH_LOAD;
                    state_n = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                // Start bit goes low during the last inhibit cycle so it leads the clock release.
                if (timer == 32'd0) begin
                    ps2_dat_oe = 1'b1;
                    timer_n    = START_LOAD;
                    guard_n    = 2'd2;
                    state_n    = S_REQUEST;
                end
            end
            S_REQUEST: begin
                ps2_dat_oe = 1'b1;
                if (fe && guard == 2'd0) begin
                    dat_bit_n = ~frame[0];
                    bitn_n    = 4'd1;
                    timer_n   = BIT_LOAD;
                    state_n   = S_DATA;
                end else if (timer == 32'd0) begin
                    state_n = S_FAIL;
                end
            end
            S_DATA: begin
                ps2_dat_oe = dat_bit;
                if (fe) begin
                    timer_n = BIT_LOAD;
                    if (bitn < 4'd10) begin
                        dat_bit_n = ~frame[bitn];
                        bitn_n    = bitn + 4'd1;
                    end else begin
                        state_n = S_ACK;
                    end
                end else if (timer == 32'd0) begin
                    state_n = S_FAIL;
                end
            end
            S_ACK: begin
                if (fe) begin
                    timer_n = BIT_LOAD;
                    state_n = dat_s ? S_FAIL : S_WAIT_IDLE;
                end else if (timer == 32'd0) begin
                    state_n = S_FAIL;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done_c  = 1'b1;
                    state_n = S_IDLE;
                end else if (timer == 32'd0) begin
                    state_n = S_FAIL;
                end
            end
            S_FAIL: begin
                error_c = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign cmd.cmd_ready = ready_c;
    assign cmd.busy      = busy_c;
    assign cmd.done      = done_c;
    assign cmd.error     = error_c;
endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - directed self-checking bench for ps2_command_tx with a PS/2 device model
module tb_ps2_command_tx;
    localparam int INH = 5000;
    localparam int ST  = 3000;
    localparam int BT  = 600;
    localparam int H   = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    int checks = 0;
    int fails  = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int run      = 0;
    int inh_len  = 0;
    logic [1:0] dat_hist = 2'b00;
    logic [1:0] lead     = 2'b00;
    logic prev_clk_oe    = 1'b0;

    ps2_command_tx_if cmd_if();

    ps2_command_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .BIT_TIMEOUT   (BT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 clk = ~clk;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always @(negedge clk) begin
        if (cmd_if.done)  done_cnt++;
        if (cmd_if.error) err_cnt++;
        if (ps2_clk_oe) begin
            run++;
        end else if (prev_clk_oe) begin
            inh_len = run;
            lead    = dat_hist;
            run     = 0;
        end
        dat_hist    = {dat_hist[0], ps2_dat_oe};
        prev_clk_oe = ps2_clk_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        cmd_if.cmd_data  = b;
        cmd_if.cmd_valid = 1'b1;
        while (cmd_if.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        chk("clk_oe_after_accept", 32'(ps2_clk_oe), 32'd1);
    endtask

    task automatic dev_xfer(input int pulses, input bit ack, output logic [10:0] smp);
        int n;
        smp = '0;
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 2 * INH) begin
            @(negedge clk);
            n++;
        end
        chk("clk_release", 32'(ps2_clk_oe), 32'd0);
        repeat (10) @(negedge clk);
        smp[0] = ps2_dat_in;
        for (int k = 1; k <= pulses; k++) begin
            if (k == 11 && ack) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k <= 10) smp[k] = ps2_dat_in;
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (cmd_if.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(cmd_if.done), 32'd1);
    endtask

    initial begin
        logic [10:0] smp;
        int cnt;
        cmd_if.cmd_data  = 8'h00;
        cmd_if.cmd_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("rst_busy",   32'(cmd_if.busy), 32'd0);
        chk("rst_ready",  32'(cmd_if.cmd_ready), 32'd1);
        chk("rst_done",   32'(cmd_if.done), 32'd0);
        chk("rst_error",  32'(cmd_if.error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Normal send of 0xED with acknowledge
        send_byte(8'hED);
        chk("busy_inhibit", 32'(cmd_if.busy), 32'd1);
        dev_xfer(12, 1'b1, smp);
        chk("ed_line_samples", 32'(smp), 32'h7DA);
        wait_done(20);
        chk("done_busy_high", 32'(cmd_if.busy), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(cmd_if.done), 32'd0);
        chk("busy_after_done", 32'(cmd_if.busy), 32'd0);
        chk("ready_after_done", 32'(cmd_if.cmd_ready), 32'd1);
        chk("inhibit_len", 32'(inh_len), 32'(INH));
        chk("start_lead", 32'(lead), 32'h1);
        chk("done_cnt_1", 32'(done_cnt), 32'd1);
        chk("err_cnt_0", 32'(err_cnt), 32'd0);

        // No device: start timeout measured from clock release
        send_byte(8'h01);
        cnt = 0;
        while (ps2_clk_oe !== 1'b0 && cnt < 2 * INH) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (cmd_if.error !== 1'b1 && cnt < ST + 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("start_timeout_window", 32'(cnt >= ST - 2 && cnt <= ST + 2), 32'd1);
        chk("fail_clk_released", 32'(ps2_clk_oe), 32'd0);
        chk("fail_dat_released", 32'(ps2_dat_oe), 32'd0);
        @(negedge clk);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);

        // Missing acknowledge
        send_byte(8'h00);
        dev_xfer(12, 1'b0, smp);
        chk("zero_line_samples", 32'(smp), 32'h600);
        chk("noack_err_cnt", 32'(err_cnt), 32'd2);
        chk("noack_done_cnt", 32'(done_cnt), 32'd1);

        // Stalled clock after bit 4, with 0xFF requested while busy
        send_byte(8'h5A);
        dev_xfer(4, 1'b0, smp);
        @(negedge clk);
        cmd_if.cmd_data  = 8'hFF;
        cmd_if.cmd_valid = 1'b1;
        cnt = 1;
        @(negedge clk);
        chk("held_req_not_ready", 32'(cmd_if.cmd_ready), 32'd0);
        while (cmd_if.error !== 1'b1 && cnt < BT + 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("bit_timeout_window", 32'(cnt >= BT - 2 * H && cnt <= BT - 2 * H + 6), 32'd1);
        chk("fail_not_ready", 32'(cmd_if.cmd_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_error", 32'(cmd_if.cmd_ready), 32'd1);
        chk("error_one_cycle", 32'(cmd_if.error), 32'd0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        chk("held_req_accepted", 32'(ps2_clk_oe), 32'd1);
        dev_xfer(12, 1'b1, smp);
        chk("ff_line_samples", 32'(smp), 32'h7FE);
        wait_done(20);
        @(negedge clk);
        chk("ff_done_cnt", 32'(done_cnt), 32'd2);
        chk("ff_err_cnt", 32'(err_cnt), 32'd3);

        // Asynchronous reset during bit 6
        send_byte(8'hED);
        dev_xfer(5, 1'b0, smp);
        dev_clk_low = 1'b1;
        repeat (H / 2) @(negedge clk);
        chk("busy_before_reset", 32'(cmd_if.busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("arst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("arst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("arst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(negedge clk);
        dev_clk_low = 1'b0;
        reset = 1'b0;
        repeat (2 * H) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt), 32'd2);
        chk("arst_no_error", 32'(err_cnt), 32'd3);
        chk("arst_idle", 32'(cmd_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
